// File: rtl/fir_pkg.sv
// Shared constants and types for the sequential FIR MAC engine.
// Imported by the delay line and the engine top.
package fir_pkg;

  localparam int NTAPS   = 16;
  localparam int AW      = 4;
  localparam int DW      = 8;
  localparam int CW      = 8;
  localparam int ACCW    = 20;
  localparam int ROM_LAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef logic signed [DW-1:0] sample_t;

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] tap;
  } tap_t;

endpackage

// File: rtl/fir_delay_line.sv
// NTAPS-deep sample shift register with a tap-indexed read port.
// Cleared asynchronously so no stale history survives a reset.
module fir_delay_line
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift_en,
  input  sample_t       din,
  input  logic [AW-1:0] rd_tap,
  output sample_t       rd_data
);

  sample_t taps [NTAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        taps[k] <= '0;
      end
    end else if (shift_en) begin
      taps[0] <= din;
      for (int k = 1; k < NTAPS; k++) begin
        taps[k] <= taps[k-1];
      end
    end
  end

  assign rd_data = taps[rd_tap];

endmodule

// File: rtl/fir_mac_engine.sv
// Single-MAC FIR engine: walks the coefficient ROM once per sample
// and accumulates h[k]*x[n-k] into one output pulse.
module fir_mac_engine
  import fir_pkg::*;
(
  input  logic            clka,
  input  logic            rsta_n,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic [AW-1:0]   addra,
  input  logic [CW-1:0]   douta,
  output logic            out_valid,
  output logic [ACCW-1:0] out_data
);

  localparam logic [AW-1:0] LAST  = AW'(NTAPS - 1);
  localparam logic [AW-1:0] DLAST = AW'(ROM_LAT - 1);
  localparam int            PW    = DW + CW;

  state_t                 state_q;
  state_t                 state_d;
  logic [AW-1:0]          idx_q;
  tap_t                   pipe_q [ROM_LAT];
  tap_t                   head;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] out_q;
  logic signed [PW-1:0]   prod;
  sample_t                x_rd;
  logic                   accept;

  assign in_ready = rsta_n & (state_q == IDLE);
  assign accept   = in_valid & in_ready;
  assign head     = pipe_q[ROM_LAT-1];

  fir_delay_line u_dl (
    .clk      (clka),
    .rst_n    (rsta_n),
    .shift_en (accept),
    .din      (sample_t'(in_data)),
    .rd_tap   (head.tap),
    .rd_data  (x_rd)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = RUN;
      RUN:   if (idx_q == LAST) state_d = DRAIN;
      DRAIN: if (idx_q == DLAST) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // idx restarts on every state change, so it never wraps by overflow
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      idx_q <= '0;
    end else if (state_q != state_d) begin
      idx_q <= '0;
    end else if (state_q == RUN || state_q == DRAIN) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{vld: (state_q == RUN), tap: idx_q};
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign prod = $signed(douta) * x_rd;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= '0;
    end else if (head.vld) begin
      acc_q <= acc_q + {{(ACCW-PW){prod[PW-1]}}, prod};
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      out_q <= '0;
    end else if (state_q == DONE) begin
      out_q <= acc_q;
    end
  end

  assign addra     = (state_q == RUN) ? idx_q : '0;
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? acc_q : out_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine with a registered ROM model.
// Table vectors plus reset, backpressure and extreme sequences.
module tb_fir_mac_engine;

  logic        clka = 1'b0;
  logic        rsta_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [3:0]  addra;
  logic [7:0]  douta = '0;
  logic        out_valid;
  logic [19:0] out_data;

  logic signed [7:0] rom [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [7:0] x;
    int                y;
  } vec_t;

  vec_t vt [33];

  fir_mac_engine dut (
    .clka      (clka),
    .rsta_n    (rsta_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .addra     (addra),
    .douta     (douta),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clka = ~clka;

  always @(posedge clka) douta <= rom[addra];

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    #2 rsta_n = 1'b0;
    repeat (2) @(posedge clka);
    #1 rsta_n = 1'b1;
    @(posedge clka);
    #1;
  endtask

  task automatic send(input logic signed [7:0] x,
                      input int exp,
                      input string nm);
    int n;
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clka);
      #1;
      g++;
    end
    chk({nm, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clka);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      if (in_ready !== 1'b0)
        chk({nm, "_busy"}, in_ready, 0);
      if (addra !== ((n <= 16) ? 4'(n - 1) : 4'd0))
        chk({nm, "_addra"}, addra, (n <= 16) ? n - 1 : 0);
      @(posedge clka);
      #1;
      n++;
    end
    chk({nm, "_lat"}, n, 18);
    chk({nm, "_data"}, $signed(out_data), exp);
    chk({nm, "_rdydone"}, in_ready, 0);
    @(posedge clka);
    #1;
    chk({nm, "_pulse"}, out_valid, 0);
    chk({nm, "_hold"}, $signed(out_data), exp);
  endtask

  int hist [16];
  int expq [$];
  int acc_cnt;
  int out_cnt;
  int last_acc;
  int y;
  int g;

  initial begin
    for (int k = 0; k < 16; k++) rom[k] = 8'(k + 1);

    vt[0] = '{8'sd1, 1};
    for (int i = 1; i < 16; i++) vt[i] = '{8'sd0, i + 1};
    for (int m = 1; m <= 16; m++)
      vt[15 + m] = '{8'sd1, m * (m + 1) / 2};
    vt[32] = '{8'sd1, 136};

    #12;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addra", addra, 0);
    chk("rst_data", out_data, 0);
    @(posedge clka);
    #1 rsta_n = 1'b1;
    @(posedge clka);
    #1;
    chk("idle_ready", in_ready, 1);

    for (int i = 0; i < 33; i++)
      send(vt[i].x, vt[i].y, $sformatf("vec%0d", i));

    // reset in the middle of a run
    in_valid = 1'b1;
    in_data  = 8'sd5;
    @(posedge clka);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clka);
    #2 rsta_n = 1'b0;
    #1;
    chk("mid_addra", addra, 0);
    chk("mid_valid", out_valid, 0);
    chk("mid_ready", in_ready, 0);
    @(posedge clka);
    #1 rsta_n = 1'b1;
    g = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clka);
      #1;
      if (out_valid) g++;
    end
    chk("mid_nopulse", g, 0);
    send(8'sd1, 1, "post_rst");

    // backpressure: in_valid high, data changing every cycle
    do_reset();
    for (int k = 0; k < 16; k++) hist[k] = 0;
    acc_cnt  = 0;
    out_cnt  = 0;
    last_acc = -1;
    in_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      in_data = 8'(c * 7 + 3);
      if (out_valid) begin
        out_cnt++;
        if (expq.size() == 0) chk("bp_extra", 1, 0);
        else chk("bp_data", $signed(out_data), expq.pop_front());
      end
      if (in_ready) begin
        if (last_acc >= 0) chk("bp_gap", c - last_acc, 19);
        last_acc = c;
        acc_cnt++;
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'($signed(in_data));
        y = 0;
        for (int k = 0; k < 16; k++) y += int'(rom[k]) * hist[k];
        expq.push_back(y);
      end
      @(posedge clka);
      #1;
    end
    in_valid = 1'b0;
    g = 0;
    while (expq.size() > 0 && g < 30) begin
      if (out_valid) begin
        out_cnt++;
        chk("bp_data", $signed(out_data), expq.pop_front());
      end
      @(posedge clka);
      #1;
      g++;
    end
    chk("bp_pending", expq.size(), 0);
    chk("bp_count", out_cnt, acc_cnt);
    chk("bp_accepts", acc_cnt, 5);

    // extremes
    for (int k = 0; k < 16; k++) rom[k] = -8'sd128;
    do_reset();
    for (int m = 1; m <= 16; m++)
      send(-8'sd128, m * 16384, $sformatf("ext_neg%0d", m));
    for (int m = 1; m <= 16; m++)
      send(8'sd127, (16 - m) * 16384 - m * 16256,
           $sformatf("ext_pos%0d", m));
    chk("ext_raw", out_data, 20'hC0800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
